// File: rtl/reg_access_ctrl_pkg.sv
// Shared register-bank types: field access kind (also used by the field block),
// access-controller FSM states, and the read data returned on a failed access.
package common;

  typedef enum logic {
    RO = 1'b0,
    RW = 1'b1
  } access_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } reg_acc_state_t;

  localparam int unsigned ERR_RDATA = 0;

  function automatic access_t access_of(input logic rw_bit);
    return rw_bit ? RW : RO;
  endfunction

endpackage

// File: rtl/reg_access_ctrl_addr_decode.sv
// Combinational register-index decoder: hit detection, one-hot select and
// access-error flag (miss, or write to a read-only register).
module reg_addr_decode
  import common::*;
#(
  parameter int unsigned          NUM_REGS = 8,
  parameter int unsigned          ADDR_W   = 4,
  parameter logic [NUM_REGS-1:0]  RW_MASK  = {NUM_REGS{1'b1}}
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                wr_i,
  output logic                hit_o,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                err_o
);

  access_t acc;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    hit_o    = 1'b0;
    onehot_o = '0;
    acc      = RO;
    // A match only exists for indices below NUM_REGS, which is exactly the hit rule.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        hit_o       = 1'b1;
        onehot_o[i] = 1'b1;
        acc         = access_of(RW_MASK[i]);
      end
    end
    err_o = ~hit_o | (wr_i & (acc != RW));
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-bank access controller: valid/ready request in, one-hot field write
// pulse and read mux, registered response. Optional macro REG_ACCESS_PARITY_EN
// adds even-parity checking of write data via the req_wpar port.
module reg_access_ctrl
  import common::*;
#(
  parameter int unsigned          NUM_REGS = 8,
  parameter int unsigned          ADDR_W   = 4,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [NUM_REGS-1:0]  RW_MASK  = {NUM_REGS{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
`ifdef REG_ACCESS_PARITY_EN
  input  logic                       req_wpar,
`endif
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_REGS-1:0]        reg_wr_en,
  output logic [DATA_W-1:0]          reg_write_val,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rd_val
);

  reg_acc_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] write_val_q, write_val_d;

  logic                dec_hit;
  logic [NUM_REGS-1:0] dec_onehot;
  logic                dec_err;
  logic                par_err;
  logic                access_err;
  logic [DATA_W-1:0]   rd_slice;
  logic                accept;

  assign accept = (state_q == IDLE) & req_valid & ~reset;

`ifdef REG_ACCESS_PARITY_EN
  logic par_q, par_d;

  assign par_d   = accept ? req_wpar : par_q;
  // Parity only guards the write path; reads ignore the captured bit.
  assign par_err = wr_q & (par_q != ^wdata_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`else
  assign par_err = 1'b0;
`endif

  reg_addr_decode #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RW_MASK  (RW_MASK)
  ) u_decode (
    .addr_i   (addr_q),
    .wr_i     (wr_q),
    .hit_o    (dec_hit),
    .onehot_o (dec_onehot),
    .err_o    (dec_err)
  );

  assign access_err = dec_err | par_err;

  always_comb begin
    rd_slice = DATA_W'(ERR_RDATA);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_onehot[i]) rd_slice = reg_rd_val[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    write_val_d = write_val_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    reg_wr_en   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = ~reset;
        if (accept) begin
          addr_d  = req_addr;
          wr_d    = req_wr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q && !access_err) begin
          reg_wr_en   = dec_onehot;
          write_val_d = wdata_q;
        end
        rdata_d = (!wr_q && !access_err && dec_hit) ? rd_slice : DATA_W'(ERR_RDATA);
        err_d   = access_err;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The broadcast value follows wdata during a good write and otherwise holds.
  assign reg_write_val = write_val_d;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      write_val_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      write_val_q <= write_val_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed self-checking bench for reg_access_ctrl with an 8-register bank
// where register 3 is read-only; a small field model sits behind reg_wr_en.
module tb_reg_access_ctrl;

  localparam int NR = 8;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_wpar = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [NR-1:0] reg_wr_en;
  logic [DW-1:0] reg_write_val;
  logic [NR*DW-1:0] reg_rd_val;

  logic [DW-1:0] fields [NR];
  logic          tb_init = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_access_ctrl #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RW_MASK  (8'b1111_0111)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
`ifdef REG_ACCESS_PARITY_EN
    .req_wpar      (req_wpar),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .reg_wr_en     (reg_wr_en),
    .reg_write_val (reg_write_val),
    .reg_rd_val    (reg_rd_val)
  );

  // Field model: initial contents, then updated by the write pulse.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (tb_init) fields[i] <= (i == 5) ? 32'h1234_5678 : (i == 3) ? 32'hCAFE_0003 : 32'h1000_0000 + i;
      else if (reg_wr_en[i]) fields[i] <= reg_write_val;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) reg_rd_val[i*DW +: DW] = fields[i];
  end

  // One full transaction with rsp_ready=1; returns what was seen in cycles 1 and 2.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic par,
                       output logic [NR-1:0] wen_c1, output logic [DW-1:0] wval_c1, output logic rv_c1,
                       output logic rdy_c1, output logic rv_c2, output logic [DW-1:0] rdata,
                       output logic err, output logic [NR-1:0] wen_c2);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wpar = par; rsp_ready = 1'b1;
    @(negedge clk);
    wen_c1 = reg_wr_en; wval_c1 = reg_write_val; rv_c1 = rsp_valid; rdy_c1 = req_ready;
    req_valid = 1'b0;
    @(negedge clk);
    rv_c2 = rsp_valid; rdata = rsp_rdata; err = rsp_err; wen_c2 = reg_wr_en;
  endtask

  logic [NR-1:0] w1, w2;
  logic [DW-1:0] wv, rd;
  logic          v1, r1, v2, e;

  task automatic test_reset();
    #2;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    n_checks++; if (reg_wr_en !== 8'h00) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
    n_checks++; if (reg_write_val !== 32'h0) begin n_fail++; $display("FAIL reset_write_val: got %h want 0", reg_write_val); end
    repeat (2) @(negedge clk);
    reset = 1'b0; tb_init = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    issue(1'b1, 4'd2, 32'hDEAD_BEEF, ^32'hDEAD_BEEF, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (w1 !== 8'b0000_0100) begin n_fail++; $display("FAIL wr_wen_c1: got %b want 00000100", w1); end
    n_checks++; if (wv !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_write_val: got %h want deadbeef", wv); end
    n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_valid_c1: got %b want 0", v1); end
    n_checks++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL wr_ready_c1: got %b want 0", r1); end
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid_c2: got %b want 1", v2); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", e); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rd); end
    n_checks++; if (w2 !== 8'h00) begin n_fail++; $display("FAIL wr_wen_c2: got %b want 0", w2); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_drop: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after: got %b want 1", req_ready); end
    n_checks++; if (fields[2] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_field2: got %h want deadbeef", fields[2]); end
    n_checks++; if (reg_write_val !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_val_hold: got %h want deadbeef", reg_write_val); end
  endtask

  task automatic test_read();
    issue(1'b0, 4'd5, 32'hFFFF_FFFF, 1'b0, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd5_rdata: got %h want 12345678", rd); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd5_err: got %b want 0", e); end
    n_checks++; if (w1 !== 8'h00) begin n_fail++; $display("FAIL rd5_wen: got %b want 0", w1); end
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL rd5_rsp_valid: got %b want 1", v2); end
    issue(1'b0, 4'd2, 32'h0, 1'b0, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_after_wr: got %h want deadbeef", rd); end
  endtask

  task automatic test_errors();
    issue(1'b1, 4'd9, 32'h5555_AAAA, ^32'h5555_AAAA, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL miss_wr_err: got %b want 1", e); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL miss_wr_rdata: got %h want 0", rd); end
    n_checks++; if (w1 !== 8'h00) begin n_fail++; $display("FAIL miss_wr_wen: got %b want 0", w1); end
    n_checks++; if (wv !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL miss_wr_val_hold: got %h want deadbeef", wv); end
    issue(1'b1, 4'd3, 32'h0BAD_0BAD, ^32'h0BAD_0BAD, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ro_wr_err: got %b want 1", e); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ro_wr_rdata: got %h want 0", rd); end
    n_checks++; if (w1 !== 8'h00) begin n_fail++; $display("FAIL ro_wr_wen: got %b want 0", w1); end
    issue(1'b0, 4'd3, 32'h0, 1'b0, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ro_rd_err: got %b want 0", e); end
    n_checks++; if (rd !== 32'hCAFE_0003) begin n_fail++; $display("FAIL ro_rd_rdata: got %h want cafe0003", rd); end
    issue(1'b0, 4'd12, 32'h0, 1'b0, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL miss_rd_err: got %b want 1", e); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL miss_rd_rdata: got %h want 0", rd); end
  endtask

  task automatic test_parity();
`ifdef REG_ACCESS_PARITY_EN
    issue(1'b1, 4'd1, 32'h0000_0001, 1'b0, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL par_bad_err: got %b want 1", e); end
    n_checks++; if (w1 !== 8'h00) begin n_fail++; $display("FAIL par_bad_wen: got %b want 0", w1); end
`endif
    issue(1'b1, 4'd1, 32'h0000_0001, 1'b1, w1, wv, v1, r1, v2, rd, e, w2);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL par_good_err: got %b want 0", e); end
    n_checks++; if (w1 !== 8'b0000_0010) begin n_fail++; $display("FAIL par_good_wen: got %b want 00000010", w1); end
    n_checks++; if (wv !== 32'h0000_0001) begin n_fail++; $display("FAIL par_good_val: got %h want 00000001", wv); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5; rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_access: got %b want 0", req_ready); end
    req_addr = 4'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, rsp_valid); end
      n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want 12345678", k, rsp_rdata); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d]: got %b want 0", k, rsp_err); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: got %b want 0", req_ready); end
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_rdata !== 32'h1000_0006) begin n_fail++; $display("FAIL bp_next_rdata: got %h want 10000006", rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd7; req_wdata = 32'hA5A5_A5A5; req_wpar = ^32'hA5A5_A5A5; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (reg_wr_en !== 8'b1000_0000) begin n_fail++; $display("FAIL rst_mid_wen_pre: got %b want 10000000", reg_wr_en); end
    reset = 1'b1;
    #1;
    n_checks++; if (reg_wr_en !== 8'h00) begin n_fail++; $display("FAIL rst_mid_wen_drop: got %b want 0", reg_wr_en); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", req_ready); end
    n_checks++; if (reg_write_val !== 32'h0) begin n_fail++; $display("FAIL rst_mid_val: got %h want 0", reg_write_val); end
    @(negedge clk);
    n_checks++; if (fields[7] !== 32'h1000_0007) begin n_fail++; $display("FAIL rst_mid_field7: got %h want 10000007", fields[7]); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_rel: got %b want 1", req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp[%0d]: got %b want 0", k, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_parity();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
- Register-bank access controller that sits directly upstream of the per-register field instances.
- Accepts single-beat read/write requests on a valid/ready bus and decodes the address.
- Drives a one-hot write-enable and broadcast write value into the fields, and muxes field values back.
- Returns a response with read data and an error flag. This is the only write path into RW fields.

Parameters:
- NUM_REGS, 8, number of registers in the bank (1..2^ADDR_W).
- ADDR_W, 4, request address width.
- DATA_W, 32, register/data width.
- RW_MASK, {NUM_REGS{1'b1}}, bit i = 1 means register i is RW (common::RW), 0 means RO (common::RO).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register index.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid & ready.
- rsp_rdata  out  DATA_W  read data (0 on writes and errors).
- rsp_err  out  1  access error.
- reg_wr_en  out  NUM_REGS  one-hot write pulse to field i.
- reg_write_val  out  DATA_W  write value broadcast to all fields.
- reg_rd_val  in  NUM_REGS*DATA_W  concatenated field values; register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (async, active-high) applies immediately:
  - state=IDLE; req_ready=0 while reset is high.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_wr_en=0, reg_write_val=0.
  - Captured addr/wr/wdata are cleared.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid, capture addr/wr/wdata and go to ACCESS.
  - ACCESS (exactly 1 cycle): req_ready=0. Decode the captured request:
    - hit = addr < NUM_REGS.
    - Write to a hit with RW_MASK[addr]=1: reg_wr_en[addr]=1 for this cycle only; reg_write_val=wdata; err=0.
    - Read to a hit: latch reg_rd_val slice into rsp_rdata; err=0. Reads of RO registers are legal.
    - Write to an RO register, or any miss: no reg_wr_en bit set; rsp_rdata=0; err=1.
    - Then go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable until rsp_ready. On the handshake, drop rsp_valid and go to IDLE.
- Latency:
  - Accept edge at cycle 0.
  - reg_wr_en high during cycle 1; the field updates at the cycle-2 edge.
  - rsp_valid rises in cycle 2.
  - Minimum 3 cycles per transaction; no pipelining, no request accepted outside IDLE.
- reg_wr_en is never multi-hot and never asserted outside ACCESS. reg_write_val holds its last value between writes.
- Read data is sampled in ACCESS. A read issued after a completed write to the same register returns the new value.
- req_valid deasserting while req_ready=0 is legal and ignored.
- Reset mid-transaction: the transaction is dropped, with no wr_en pulse and no response. A wr_en pulse already issued is not undone.

Optional Feature:
- Macro: REG_ACCESS_PARITY_EN.
- With it defined:
  - Extra port req_wpar (in, 1) carries even parity of req_wdata, captured with the request.
  - A write whose captured parity mismatches ^wdata is treated as an error: err=1, no reg_wr_en.
  - Reads ignore req_wpar.
- Without it: no port, no check; behaviour is exactly as above.

Decomposition:
- Package common holds:
  - access enum RO/RW, already shared with the field block;
  - new typedef reg_acc_state_t {IDLE, ACCESS, RESP};
  - localparam for the error rdata value (0).
- One natural sub-module, reg_addr_decode (combinational): addr, wr, RW_MASK → hit, onehot, err.

Test Plan:
- Write 0xDEADBEEF to addr 2 (RW), rsp_ready=1 → reg_wr_en=8'b0000_0100 for exactly cycle 1, reg_write_val=0xDEADBEEF, rsp_valid in cycle 2 with err=0, rdata=0.
- reg_rd_val slice 5 = 0x12345678, read addr 5 → rsp_rdata=0x12345678, err=0, reg_wr_en stays 0.
- Error cases, each → err=1, rdata=0, no wr_en pulse:
  - write addr 9 with NUM_REGS=8;
  - write addr 3 with RW_MASK[3]=0.
  - Also: read addr 3 with RW_MASK[3]=0 → err=0, value returned.
- Read with rsp_ready held 0 for 5 cycles while req_valid stays 1 → rsp_valid/rdata/err stable; req_ready=0 throughout; next request accepted only in the cycle after the handshake.
- Assert reset during ACCESS of a write → reg_wr_en drops immediately, no response, req_ready=0 during reset and 1 in the first cycle after release.
- With REG_ACCESS_PARITY_EN, write 0x00000001 with req_wpar=0 → err=1, no wr_en; with req_wpar=1 → normal write.
